// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion sequencer.
//   adc_state_e : sequencer FSM states
//   ADC_BITS    : converter result width
//   ARM_TIMEOUT / CONV_TIMEOUT : watchdog limits in sclk cycles
//   MIN_SAMPLE_PERIOD : smallest usable SAMPLE_PERIOD
//   next_chan() : round-robin channel pick
package adc_pkg;

  localparam int unsigned ADC_BITS          = 10;
  localparam int unsigned ARM_TIMEOUT       = 3;
  localparam int unsigned CONV_TIMEOUT      = 20;
  localparam int unsigned MIN_SAMPLE_PERIOD = 20;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StArm     = 3'd2,
    StConvert = 3'd3,
    StCapture = 3'd4,
    StGap     = 3'd5
  } adc_state_e;

  // Lowest enabled channel index after 'last', wrapping around. Caller
  // guarantees mask is nonzero.
  function automatic logic next_chan(input logic last, input logic [1:0] mask);
    if (last) next_chan = mask[0] ? 1'b0 : 1'b1;
    else      next_chan = mask[1] ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/adc_avg4.sv
// Four-entry moving average of raw ADC results for one channel.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : accept din_i this cycle
//   preload_i    : with load_i, fill the whole history with din_i
//   din_i        : raw converter result
//   avg_o        : registered (sum of last 4) >> 2
module adc_avg4
  import adc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                preload_i,
  input  logic [ADC_BITS-1:0] din_i,
  output logic [ADC_BITS-1:0] avg_o
);

  logic [ADC_BITS-1:0] hist_q [4];
  logic [ADC_BITS-1:0] hist_d [4];
  logic [ADC_BITS+1:0] sum_q, sum_d;
  logic [ADC_BITS-1:0] avg_q, avg_d;

  always_comb begin
    for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];
    sum_d = sum_q;
    avg_d = avg_q;
    if (load_i) begin
      if (preload_i) begin
        for (int i = 0; i < 4; i++) hist_d[i] = din_i;
        sum_d = {din_i, 2'b00};
      end else begin
        hist_d[0] = din_i;
        for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
        // Running sum: drop the oldest entry, add the newest.
        sum_d = sum_q - {2'b00, hist_q[3]} + {2'b00, din_i};
      end
      avg_d = sum_d[ADC_BITS+1:2];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/adc_sequencer.sv
// Autonomous conversion scheduler for a 2-channel 10-bit SPI ADC.
// Issues a start pulse every SAMPLE_PERIOD sclk cycles (minimum 20),
// round-robins over enabled channels, captures each result per channel and
// flags a stalled converter via a sticky watchdog fault.
// Optional build macro ADC_SEQ_AVG_EN: sample0/1 become 4-sample averages.
// Ports:
//   sclk, reset        : clock, asynchronous active-high reset
//   enable, chan_mask  : run control and per-channel enables
//   ncs, voltage       : converter chip select (low = busy) and result
//   start, channel     : one-cycle start pulse and channel select
//   sample0, sample1   : latest result per channel
//   sample_valid/_chan : update strobe and channel of that update
//   busy, fault        : not-idle flag, sticky watchdog flag
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 32
) (
  input  logic                sclk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          chan_mask,
  input  logic                ncs,
  input  logic [ADC_BITS-1:0] voltage,
  output logic                start,
  output logic                channel,
  output logic [ADC_BITS-1:0] sample0,
  output logic [ADC_BITS-1:0] sample1,
  output logic                sample_valid,
  output logic                sample_chan,
  output logic                busy,
  output logic                fault
);

  localparam int unsigned CntW = $clog2(SAMPLE_PERIOD + CONV_TIMEOUT + 8);

  adc_state_e      state_q, state_d;
  logic [CntW-1:0] period_q, period_d;
  logic [4:0]      tmo_q, tmo_d;
  logic            channel_q, channel_d;
  logic            first_q, first_d;
  logic            fault_q, fault_d;
  logic            valid_q, valid_d;
  logic            schan_q, schan_d;
  logic            capture, restart, go;

  assign go = enable && (chan_mask != 2'b00);

  always_comb begin
    state_d   = state_q;
    period_d  = (period_q == '1) ? period_q : period_q + 1'b1;
    tmo_d     = tmo_q + 1'b1;
    channel_d = channel_q;
    first_d   = first_q;
    fault_d   = fault_q;
    valid_d   = 1'b0;
    schan_d   = schan_q;
    capture   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!enable) fault_d = 1'b0;
        if (go) state_d = StStart;
      end
      StStart: begin
        tmo_d   = '0;
        state_d = StArm;
      end
      StArm: begin
        if (!ncs) begin
          tmo_d   = '0;
          state_d = StConvert;
        end else if (tmo_q == 5'(ARM_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = StGap;
        end
      end
      StConvert: begin
        if (ncs) begin
          // Result is registered on entry to CAPTURE so the strobe and the
          // new sample are visible together during the CAPTURE cycle.
          capture = 1'b1;
          valid_d = 1'b1;
          schan_d = channel_q;
          state_d = StCapture;
        end else if (tmo_q == 5'(CONV_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = StGap;
        end
      end
      StCapture: state_d = StGap;
      StGap: begin
        if (period_q >= CntW'(SAMPLE_PERIOD - 1)) state_d = go ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Channel only moves on entry to START; after reset channel 0 goes first.
    if (state_d == StStart && state_q != StStart) begin
      channel_d = next_chan(first_q ? 1'b1 : channel_q, chan_mask);
      first_d   = 1'b0;
      period_d  = '0;
    end
    restart = (state_q == StIdle) && (state_d == StStart);
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      period_q  <= '0;
      tmo_q     <= '0;
      channel_q <= 1'b0;
      first_q   <= 1'b1;
      fault_q   <= 1'b0;
      valid_q   <= 1'b0;
      schan_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
      channel_q <= channel_d;
      first_q   <= first_d;
      fault_q   <= fault_d;
      valid_q   <= valid_d;
      schan_q   <= schan_d;
    end
  end

`ifdef ADC_SEQ_AVG_EN
  // Per-channel preload flag: the first capture after reset or a restart
  // from IDLE seeds that channel's whole history.
  logic [1:0] fresh_q, fresh_d;

  always_comb begin
    fresh_d = fresh_q;
    if (restart) fresh_d = 2'b11;
    if (capture) fresh_d[channel_q] = 1'b0;
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) fresh_q <= 2'b11;
    else       fresh_q <= fresh_d;
  end

  adc_avg4 u_avg0 (
    .clk_i    (sclk),
    .rst_i    (reset),
    .load_i   (capture && !channel_q),
    .preload_i(fresh_q[0]),
    .din_i    (voltage),
    .avg_o    (sample0)
  );

  adc_avg4 u_avg1 (
    .clk_i    (sclk),
    .rst_i    (reset),
    .load_i   (capture && channel_q),
    .preload_i(fresh_q[1]),
    .din_i    (voltage),
    .avg_o    (sample1)
  );
`else
  logic [ADC_BITS-1:0] sample0_q, sample1_q;
  logic                unused_restart;

  assign unused_restart = restart;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      sample0_q <= '0;
      sample1_q <= '0;
    end else if (capture) begin
      if (channel_q) sample1_q <= voltage;
      else           sample0_q <= voltage;
    end
  end

  assign sample0 = sample0_q;
  assign sample1 = sample1_q;
`endif

  assign start        = (state_q == StStart);
  assign busy         = (state_q != StIdle);
  assign channel      = channel_q;
  assign fault        = fault_q;
  assign sample_valid = valid_q;
  assign sample_chan  = schan_q;

endmodule
